// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin, one-hot active-low grants, hidden arbitration
// during transfers, and revocation of grants left unused on an idle bus.
module pci_bus_arbiter #(
  parameter int N_MASTERS    = 4,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                 CLK,
  input  logic                 REST,
  input  logic [N_MASTERS-1:0] REQ_N,
  input  logic                 FRAME,
  input  logic                 IRDY,
  output logic [N_MASTERS-1:0] GNT_N,
  output logic [2:0]           OWNER,
  output logic                 OWNER_VALID,
  output logic                 TIMEOUT
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_BUSY     = 2'd2,
    ST_HANDOVER = 2'd3
  } state_t;

  localparam logic [2:0]           LAST_RST   = 3'(N_MASTERS - 1);
  localparam logic [4:0]           TIMER_LAST = 5'(IDLE_TIMEOUT - 1);
  localparam logic [N_MASTERS-1:0] ALL_HIGH   = {N_MASTERS{1'b1}};

  state_t                 state_r;
  logic [2:0]             last_r;
  logic [2:0]             owner_r;
  logic [4:0]             timer_r;
  logic                   idle_q_r;
  logic [N_MASTERS-1:0]   gnt_n_r;
  logic                   owner_valid_r;
  logic                   timeout_r;

  logic                   idle_s;
  logic                   start_s;
  logic [3:0]             win_s;
  logic                   own_release_s;
  logic                   others_req_s;

  // Nearest requester after the last grant; bit 3 flags that anyone is requesting.
  function automatic logic [3:0] pick_winner(input logic [N_MASTERS-1:0] req_n,
                                             input logic [2:0] last);
    logic [3:0] best;
    int         best_d;
    int         d;
    best   = 4'd0;
    best_d = N_MASTERS;
    for (int j = 0; j < N_MASTERS; j++) begin
      d = (j + 2 * N_MASTERS - int'(last) - 1) % N_MASTERS;
      if (!req_n[j] && (d < best_d)) begin
        best   = {1'b1, 3'(j)};
        best_d = d;
      end
    end
    return best;
  endfunction

  function automatic logic [N_MASTERS-1:0] grant_vec(input logic [2:0] w);
    logic [N_MASTERS-1:0] v;
    for (int j = 0; j < N_MASTERS; j++) begin
      v[j] = (3'(j) == w) ? 1'b0 : 1'b1;
    end
    return v;
  endfunction

  assign idle_s  = FRAME & IRDY;
  assign start_s = ~FRAME & idle_q_r;
  assign win_s   = pick_winner(REQ_N, last_r);

  // Split requests into the current owner's and everybody else's.
  always_comb begin
    own_release_s = 1'b1;
    others_req_s  = 1'b0;
    for (int j = 0; j < N_MASTERS; j++) begin
      if (3'(j) == owner_r) begin
        own_release_s = REQ_N[j];
      end else begin
        others_req_s = others_req_s | ~REQ_N[j];
      end
    end
  end

  // Arbitration state machine with registered outputs.
  always_ff @(posedge CLK) begin
    if (!REST) begin
      state_r       <= ST_IDLE;
      last_r        <= LAST_RST;
      owner_r       <= 3'd0;
      timer_r       <= 5'd0;
      idle_q_r      <= 1'b1;
      gnt_n_r       <= ALL_HIGH;
      owner_valid_r <= 1'b0;
      timeout_r     <= 1'b0;
    end else begin
      idle_q_r  <= idle_s;
      timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          owner_valid_r <= 1'b0;
          if (win_s[3]) begin
            state_r <= ST_GRANT;
            gnt_n_r <= grant_vec(win_s[2:0]);
            owner_r <= win_s[2:0];
            last_r  <= win_s[2:0];
            timer_r <= 5'd0;
          end else begin
            state_r <= ST_IDLE;
            gnt_n_r <= ALL_HIGH;
          end
        end
        ST_GRANT: begin
          if (start_s) begin
            state_r       <= ST_BUSY;
            owner_valid_r <= 1'b1;
            timer_r       <= 5'd0;
          end else if (own_release_s) begin
            state_r <= ST_HANDOVER;
            gnt_n_r <= ALL_HIGH;
          end else if (!idle_s) begin
            // previous owner still on the bus: the new owner's idle time does not count
            timer_r <= 5'd0;
          end else if (timer_r == TIMER_LAST) begin
            state_r   <= ST_HANDOVER;
            gnt_n_r   <= ALL_HIGH;
            timeout_r <= 1'b1;
          end else begin
            timer_r <= timer_r + 5'd1;
          end
        end
        ST_BUSY: begin
          if (others_req_s || own_release_s) begin
            // owner keeps FRAME/IRDY and completes its transfer without GNT
            state_r       <= ST_HANDOVER;
            gnt_n_r       <= ALL_HIGH;
            owner_valid_r <= 1'b0;
          end else if (idle_s) begin
            state_r       <= ST_GRANT;
            owner_valid_r <= 1'b0;
            timer_r       <= 5'd0;
          end else begin
            state_r <= ST_BUSY;
          end
        end
        ST_HANDOVER: begin
          owner_valid_r <= 1'b0;
          if (win_s[3]) begin
            state_r <= ST_GRANT;
            gnt_n_r <= grant_vec(win_s[2:0]);
            owner_r <= win_s[2:0];
            last_r  <= win_s[2:0];
            timer_r <= 5'd0;
          end else begin
            state_r <= ST_IDLE;
            gnt_n_r <= ALL_HIGH;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          gnt_n_r       <= ALL_HIGH;
          owner_valid_r <= 1'b0;
          timer_r       <= 5'd0;
        end
      endcase
    end
  end

  assign GNT_N       = gnt_n_r;
  assign OWNER       = owner_r;
  assign OWNER_VALID = owner_valid_r;
  assign TIMEOUT     = timeout_r;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Vector-table bench for pci_bus_arbiter (N_MASTERS=4, IDLE_TIMEOUT=16) with an
// expected-result queue filled at drive time and drained after each clock edge.
module tb_pci_bus_arbiter;

  logic       CLK = 1'b0;
  logic       REST;
  logic [3:0] REQ_N;
  logic       FRAME;
  logic       IRDY;
  logic [3:0] GNT_N;
  logic [2:0] OWNER;
  logic       OWNER_VALID;
  logic       TIMEOUT;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rest;
    logic [3:0] req_n;
    logic       frame;
    logic       irdy;
    logic [3:0] gnt_n;
    logic [2:0] owner;
    logic       ov;
    logic       to;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  pci_bus_arbiter #(.N_MASTERS(4), .IDLE_TIMEOUT(16)) dut (
    .CLK(CLK), .REST(REST), .REQ_N(REQ_N), .FRAME(FRAME), .IRDY(IRDY),
    .GNT_N(GNT_N), .OWNER(OWNER), .OWNER_VALID(OWNER_VALID), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic add(input logic rest, input logic [3:0] req, input logic f, input logic i,
                     input logic [3:0] g, input logic [2:0] o, input logic ov, input logic to);
    vec_t v;
    v = '{rest, req, f, i, g, o, ov, to};
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one vector before the edge, then check outputs 1 time unit after it.
  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    REST  = v.rest;
    REQ_N = v.req_n;
    FRAME = v.frame;
    IRDY  = v.irdy;
    sb.push_back(v);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    cmp("gnt_n", idx, GNT_N, e.gnt_n);
    if ((e.gnt_n != 4'hf) || !e.rest) cmp("owner", idx, {1'b0, OWNER}, {1'b0, e.owner});
    cmp("owner_valid", idx, {3'b000, OWNER_VALID}, {3'b000, e.ov});
    cmp("timeout", idx, {3'b000, TIMEOUT}, {3'b000, e.to});
  endtask

  task automatic step(input logic rest, input logic [3:0] req, input logic f, input logic i,
                      input logic [3:0] g, input logic [2:0] o, input logic ov, input logic to,
                      input int idx);
    vec_t v;
    v = '{rest, req, f, i, g, o, ov, to};
    run_vec(v, idx);
  endtask

  initial begin
    REST = 1'b0; REQ_N = 4'b0000; FRAME = 1'b1; IRDY = 1'b1;

    // reset with everybody requesting, then round-robin 0,1,2,3,0
    add(1'b0, 4'b0000, 1'b1, 1'b1, 4'b1111, 3'd0, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b1, 1'b1, 4'b1111, 3'd0, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b1, 4'b1110, 3'd0, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 1'b0, 1'b0, 4'b1110, 3'd0, 1'b1, 1'b0);
    add(1'b1, 4'b0000, 1'b0, 1'b0, 4'b1111, 3'd0, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b0, 4'b1101, 3'd1, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b1, 4'b1101, 3'd1, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 1'b0, 1'b0, 4'b1101, 3'd1, 1'b1, 1'b0);
    add(1'b1, 4'b0000, 1'b0, 1'b0, 4'b1111, 3'd0, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b0, 4'b1011, 3'd2, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b1, 4'b1011, 3'd2, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 1'b0, 1'b0, 4'b1011, 3'd2, 1'b1, 1'b0);
    add(1'b1, 4'b0000, 1'b0, 1'b0, 4'b1111, 3'd0, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0111, 3'd3, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b1, 4'b0111, 3'd3, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0111, 3'd3, 1'b1, 1'b0);
    add(1'b1, 4'b0000, 1'b0, 1'b0, 4'b1111, 3'd0, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b0, 4'b1110, 3'd0, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b1, 4'b1110, 3'd0, 1'b0, 1'b0);
    add(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 3'd0, 1'b0, 1'b0);
    add(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 3'd0, 1'b0, 1'b0);
    // single master 1 with a held request through a 4-cycle FRAME
    add(1'b1, 4'b1101, 1'b1, 1'b1, 4'b1101, 3'd1, 1'b0, 1'b0);
    add(1'b1, 4'b1101, 1'b1, 1'b1, 4'b1101, 3'd1, 1'b0, 1'b0);
    add(1'b1, 4'b1101, 1'b0, 1'b0, 4'b1101, 3'd1, 1'b1, 1'b0);
    add(1'b1, 4'b1101, 1'b0, 1'b0, 4'b1101, 3'd1, 1'b1, 1'b0);
    add(1'b1, 4'b1101, 1'b0, 1'b0, 4'b1101, 3'd1, 1'b1, 1'b0);
    add(1'b1, 4'b1101, 1'b0, 1'b0, 4'b1101, 3'd1, 1'b1, 1'b0);
    add(1'b1, 4'b1101, 1'b1, 1'b0, 4'b1101, 3'd1, 1'b1, 1'b0);
    add(1'b1, 4'b1101, 1'b1, 1'b1, 4'b1101, 3'd1, 1'b0, 1'b0);
    add(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 3'd0, 1'b0, 1'b0);
    add(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 3'd0, 1'b0, 1'b0);
    // hidden arbitration: master 2 busy, master 0 requests mid-transfer
    add(1'b1, 4'b1011, 1'b1, 1'b1, 4'b1011, 3'd2, 1'b0, 1'b0);
    add(1'b1, 4'b1011, 1'b0, 1'b0, 4'b1011, 3'd2, 1'b1, 1'b0);
    add(1'b1, 4'b1011, 1'b0, 1'b0, 4'b1011, 3'd2, 1'b1, 1'b0);
    add(1'b1, 4'b1010, 1'b0, 1'b0, 4'b1111, 3'd0, 1'b0, 1'b0);
    add(1'b1, 4'b1010, 1'b0, 1'b0, 4'b1110, 3'd0, 1'b0, 1'b0);
    add(1'b1, 4'b1010, 1'b0, 1'b0, 4'b1110, 3'd0, 1'b0, 1'b0);
    add(1'b1, 4'b1010, 1'b1, 1'b0, 4'b1110, 3'd0, 1'b0, 1'b0);
    add(1'b1, 4'b1010, 1'b1, 1'b1, 4'b1110, 3'd0, 1'b0, 1'b0);
    add(1'b1, 4'b1010, 1'b0, 1'b0, 4'b1110, 3'd0, 1'b1, 1'b0);
    add(1'b1, 4'b1110, 1'b0, 1'b0, 4'b1110, 3'd0, 1'b1, 1'b0);
    add(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 3'd0, 1'b0, 1'b0);
    add(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 3'd0, 1'b0, 1'b0);

    for (int k = 0; k < vecs.size(); k++) begin
      run_vec(vecs[k], k);
    end

    // idle timeout: 16 unused grant cycles, one TIMEOUT pulse, then re-grant
    step(1'b1, 4'b1110, 1'b1, 1'b1, 4'b1110, 3'd0, 1'b0, 1'b0, 100);
    for (int k = 1; k < 16; k++) begin
      step(1'b1, 4'b1110, 1'b1, 1'b1, 4'b1110, 3'd0, 1'b0, 1'b0, 100 + k);
    end
    step(1'b1, 4'b1110, 1'b1, 1'b1, 4'b1111, 3'd0, 1'b0, 1'b1, 116);
    step(1'b1, 4'b1110, 1'b1, 1'b1, 4'b1110, 3'd0, 1'b0, 1'b0, 117);
    step(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 3'd0, 1'b0, 1'b0, 118);
    step(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 3'd0, 1'b0, 1'b0, 119);

    // reset during master 1's transfer; master 0 wins after release
    step(1'b1, 4'b1101, 1'b1, 1'b1, 4'b1101, 3'd1, 1'b0, 1'b0, 200);
    step(1'b1, 4'b1101, 1'b0, 1'b0, 4'b1101, 3'd1, 1'b1, 1'b0, 201);
    step(1'b0, 4'b0000, 1'b0, 1'b0, 4'b1111, 3'd0, 1'b0, 1'b0, 202);
    step(1'b1, 4'b0000, 1'b1, 1'b1, 4'b1110, 3'd0, 1'b0, 1'b0, 203);
    step(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 3'd0, 1'b0, 1'b0, 204);
    step(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 3'd0, 1'b0, 1'b0, 205);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
